// File: rtl/pw_out_serializer.sv
// ---------------------------------------------------------------------------
// pw_out_serializer
//
// Output stage of the 1x1 pointwise convolution engine. Each pixel arrives as
// one saturated COUT-channel int8 vector. ReLU can be applied when the vector
// is captured. The vector is then sent out as LANES-channel AXI-Stream beats.
// The block counts pixels within a frame so that it can mark the first beat of
// a frame (tuser), mark the last beat of a frame (tlast), and pulse frame_done
// once that last beat has been accepted.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   s_valid        input vector valid
//   s_ready        input vector accepted when s_valid && s_ready
//   s_vec          COUT*DATA_W packed vector, channel c at [c*DATA_W +: DATA_W]
//   m_axis_tvalid  output beat valid
//   m_axis_tready  downstream ready
//   m_axis_tdata   LANES*DATA_W beat, lane l carries channel beat*LANES+l
//   m_axis_tuser   first beat of first pixel of a frame
//   m_axis_tlast   last beat of last pixel of a frame
//   frame_done     one-cycle pulse after the frame's tlast beat is accepted
// ---------------------------------------------------------------------------
module pw_out_serializer #(
   parameter int DATA_W        = 8,
   parameter int COUT          = 64,
   parameter int LANES         = 8,
   parameter int RELU_EN       = 1,
   parameter int PIX_PER_FRAME = 196
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [COUT*DATA_W-1:0]    s_vec,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [LANES*DATA_W-1:0]   m_axis_tdata,
   output logic                      m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      frame_done
);

   localparam int NUM_BEATS = (COUT + LANES - 1) / LANES;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int PIX_W     = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
   localparam int BEAT_BITS = LANES * DATA_W;
   localparam int BUF_BITS  = NUM_BEATS * BEAT_BITS;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIX_PER_FRAME - 1);

   typedef enum logic [0:0] {
      IDLE,
      STREAM
   } stateT;

   stateT               r_state;
   stateT               w_nextState;
   logic [BEAT_W-1:0]   r_beatCnt;
   logic [PIX_W-1:0]    r_pixCnt;
   logic [BUF_BITS-1:0] r_buf;
   logic                r_frameDone;

   logic [BUF_BITS-1:0] w_capVec;
   logic                w_lastBeat;
   logic                w_beatAccept;
   logic                w_pixDone;
   logic                w_capture;

   assign w_lastBeat   = (r_beatCnt == LAST_BEAT);
   assign w_beatAccept = (r_state == STREAM) && m_axis_tready;
   assign w_pixDone    = w_beatAccept && w_lastBeat;
   assign w_capture    = s_valid && s_ready;

   // Build the image that gets written into the buffer. ReLU is applied here
   // so the buffer already holds final values. The buffer is sized to a whole
   // number of beats, so channels past COUT stay zero and act as the padding
   // lanes of the final beat.
   always_comb begin
      w_capVec = '0;
      for (int c = 0; c < COUT; c++) begin
         if ((RELU_EN != 0) && s_vec[c*DATA_W + DATA_W - 1]) begin
            w_capVec[c*DATA_W +: DATA_W] = '0;
         end else begin
            w_capVec[c*DATA_W +: DATA_W] = s_vec[c*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and handshake decode. While streaming, s_ready is taken
   // straight from tready on the final beat. This lets a new vector be
   // captured in the same cycle the last beat leaves, so back-to-back pixels
   // have no bubble. s_ready stays low until then, so the buffer cannot be
   // overwritten while an earlier beat is still waiting.
   always_comb begin
      w_nextState   = r_state;
      s_ready       = 1'b0;
      m_axis_tvalid = 1'b0;
      case (r_state)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               w_nextState = STREAM;
            end
         end
         STREAM: begin
            m_axis_tvalid = 1'b1;
            s_ready       = w_lastBeat && m_axis_tready;
            if (w_pixDone && !s_valid) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Capture buffer and beat counter. Capturing a vector always restarts the
   // beat count. Otherwise the count advances on every accepted beat except
   // the final one, and the final beat is cleared by the next capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf     <= '0;
         r_beatCnt <= '0;
      end else if (w_capture) begin
         r_buf     <= w_capVec;
         r_beatCnt <= '0;
      end else if (w_beatAccept && !w_lastBeat) begin
         r_beatCnt <= r_beatCnt + BEAT_W'(1);
      end
   end

   // Pixel-in-frame counter and frame_done pulse. The pulse is registered,
   // so it appears on the cycle after the tlast beat is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pixCnt    <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= w_pixDone && (r_pixCnt == LAST_PIX);
         if (w_pixDone) begin
            r_pixCnt <= (r_pixCnt == LAST_PIX) ? '0 : r_pixCnt + PIX_W'(1);
         end
      end
   end

   // Pick the buffer slice for the current beat. Outside STREAM the data bus
   // is held at zero.
   always_comb begin
      m_axis_tdata = '0;
      if (r_state == STREAM) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            if (r_beatCnt == BEAT_W'(b)) begin
               m_axis_tdata = r_buf[b*BEAT_BITS +: BEAT_BITS];
            end
         end
      end
   end

   assign m_axis_tuser = (r_state == STREAM) && (r_beatCnt == '0) && (r_pixCnt == '0);
   assign m_axis_tlast = (r_state == STREAM) && w_lastBeat && (r_pixCnt == LAST_PIX);
   assign frame_done   = r_frameDone;

endmodule

// File: tb/tb_pw_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_pw_out_serializer
//
// Bench for pw_out_serializer. It uses two instances:
//   u_dutA : COUT=64, LANES=8, RELU_EN=1, PIX_PER_FRAME=3 (frame markers)
//   u_dutB : COUT=20, LANES=8, RELU_EN=0 (padding on the final beat)
// Only one instance is driven at a time, chosen by 'sel'. When a vector is
// handed to the DUT, the beats it should produce are pushed to a queue. They
// are popped and compared as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_pw_out_serializer;

   typedef struct {
      logic [63:0] data;
      logic        user;
      logic        last;
   } beatT;

   logic         clk;
   logic         reset;
   logic         sel;
   logic         sValid;
   logic [511:0] sVec;
   logic         mTready;

   logic         aSReady, aTvalid, aTuser, aTlast, aFrameDone;
   logic [63:0]  aTdata;
   logic         bSReady, bTvalid, bTuser, bTlast, bFrameDone;
   logic [63:0]  bTdata;
   logic         aSValid, bSValid;
   logic [159:0] bSVec;

   logic         obsSReady, obsValid, obsUser, obsLast, obsFd;
   logic [63:0]  obsData;

   beatT         sbQ[$];
   logic [511:0] vecQ[$];
   logic [511:0] tmpVec;
   int           mPix;
   logic         expFd;
   int           nChecks;
   int           nErrors;

   int           tvalidCycles, runLen, maxRun, sreadyPulses;
   int           tuserCount, tlastCount, fdCount, acceptCount;
   logic [63:0]  lastData;

   assign aSValid = sValid && !sel;
   assign bSValid = sValid && sel;
   assign bSVec   = sVec[159:0];

   assign obsSReady = sel ? bSReady    : aSReady;
   assign obsValid  = sel ? bTvalid    : aTvalid;
   assign obsUser   = sel ? bTuser     : aTuser;
   assign obsLast   = sel ? bTlast     : aTlast;
   assign obsFd     = sel ? bFrameDone : aFrameDone;
   assign obsData   = sel ? bTdata     : aTdata;

   pw_out_serializer #(
      .DATA_W(8), .COUT(64), .LANES(8), .RELU_EN(1), .PIX_PER_FRAME(3)
   ) u_dutA (
      .clk           (clk),
      .reset         (reset),
      .s_valid       (aSValid),
      .s_ready       (aSReady),
      .s_vec         (sVec),
      .m_axis_tvalid (aTvalid),
      .m_axis_tready (mTready),
      .m_axis_tdata  (aTdata),
      .m_axis_tuser  (aTuser),
      .m_axis_tlast  (aTlast),
      .frame_done    (aFrameDone)
   );

   pw_out_serializer #(
      .DATA_W(8), .COUT(20), .LANES(8), .RELU_EN(0), .PIX_PER_FRAME(196)
   ) u_dutB (
      .clk           (clk),
      .reset         (reset),
      .s_valid       (bSValid),
      .s_ready       (bSReady),
      .s_vec         (bSVec),
      .m_axis_tvalid (bTvalid),
      .m_axis_tready (mTready),
      .m_axis_tdata  (bTdata),
      .m_axis_tuser  (bTuser),
      .m_axis_tlast  (bTlast),
      .frame_done    (bFrameDone)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Emergency stop in case something wedges the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison, counted, with a report on failure
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: turn an accepted vector into the beats it should produce
   task automatic pushExpected(input logic [511:0] v);
      int          cout, nb, ppf, ch;
      logic        relu;
      logic [7:0]  val;
      beatT        e;
      cout = sel ? 20 : 64;
      nb   = sel ? 3 : 8;
      ppf  = sel ? 196 : 3;
      relu = sel ? 1'b0 : 1'b1;
      for (int b = 0; b < nb; b++) begin
         e.data = '0;
         for (int l = 0; l < 8; l++) begin
            ch = b * 8 + l;
            if (ch < cout) begin
               val = v[ch*8 +: 8];
               if (relu && val[7]) val = 8'h00;
               e.data[l*8 +: 8] = val;
            end
         end
         e.user = (b == 0) && (mPix == 0);
         e.last = (b == nb - 1) && (mPix == ppf - 1);
         sbQ.push_back(e);
      end
      mPix = (mPix + 1) % ppf;
   endtask

   // Compare the DUT outputs for this cycle against the scoreboard
   task automatic checkOutput();
      logic newFd;
      beatT e;
      newFd = 1'b0;
      chk("tvalid", obsValid, (sbQ.size() != 0));
      chk("s_ready", obsSReady, (sbQ.size() == 0) || (sbQ.size() == 1 && mTready));
      chk("frame_done", obsFd, expFd);
      if (sbQ.size() != 0) begin
         e = sbQ[0];
         chk("tdata", obsData, e.data);
         chk("tuser", obsUser, e.user);
         chk("tlast", obsLast, e.last);
         if (mTready) begin
            void'(sbQ.pop_front());
            if (e.last) newFd = 1'b1;
         end
      end
      if (obsValid) begin
         tvalidCycles++;
         runLen++;
         if (runLen > maxRun) maxRun = runLen;
         if (obsSReady) sreadyPulses++;
         if (mTready) begin
            acceptCount++;
            lastData = obsData;
            if (obsUser) tuserCount++;
            if (obsLast) tlastCount++;
         end
      end else begin
         runLen = 0;
      end
      if (obsFd) fdCount++;
      expFd = newFd;
   endtask

   // Drive one cycle. The upstream holds the head vector until it is accepted.
   task automatic applyStimulus(input logic rdy);
      sValid  = (vecQ.size() != 0);
      sVec    = sValid ? vecQ[0] : '0;
      mTready = rdy;
      #1;
      checkOutput();
      if (sValid && obsSReady) begin
         pushExpected(vecQ[0]);
         void'(vecQ.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic readyFor(input int mode, input int k);
      if (mode == 0) return 1'b1;
      return (k % 4 == 0) || (k % 4 == 3);
   endfunction

   task automatic runUntilDrained(input int mode, input int maxCycles);
      int k;
      k = 0;
      while ((vecQ.size() != 0 || sbQ.size() != 0) && k < maxCycles) begin
         applyStimulus(readyFor(mode, k));
         k++;
      end
      chk("drain_timeout", (vecQ.size() != 0 || sbQ.size() != 0), 1'b0);
      applyStimulus(1'b1);
   endtask

   task automatic doReset(input int n);
      reset  = 1'b1;
      sValid = 1'b0;
      sVec   = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      sbQ.delete();
      vecQ.delete();
      mPix  = 0;
      expFd = 1'b0;
      #1;
      chk("rst_tvalid", obsValid, 1'b0);
      chk("rst_s_ready", obsSReady, 1'b1);
      chk("rst_tdata", obsData, 64'h0);
      chk("rst_tuser", obsUser, 1'b0);
      chk("rst_tlast", obsLast, 1'b0);
      chk("rst_frame_done", obsFd, 1'b0);
   endtask

   task automatic clearStats();
      tvalidCycles = 0; runLen = 0; maxRun = 0; sreadyPulses = 0;
      tuserCount = 0; tlastCount = 0; fdCount = 0; acceptCount = 0;
      lastData = '0;
   endtask

   task automatic randomVec();
      for (int w = 0; w < 16; w++) tmpVec[w*32 +: 32] = $urandom;
   endtask

   // Directed sequence
   initial begin
      sel = 1'b0; reset = 1'b1; sValid = 1'b0; sVec = '0; mTready = 1'b1;
      nChecks = 0; nErrors = 0; mPix = 0; expFd = 1'b0;
      clearStats();
      @(posedge clk);
      #1;
      doReset(2);

      $display("[TB] single pixel with ReLU");
      clearStats();
      for (int c = 0; c < 64; c++) tmpVec[c*8 +: 8] = 8'(c - 32);
      vecQ.push_back(tmpVec);
      runUntilDrained(0, 50);
      chk("t1_valid_cycles", tvalidCycles, 8);
      chk("t1_tuser_count", tuserCount, 1);
      chk("t1_beat7", lastData, 64'h1F1E1D1C1B1A1918);

      $display("[TB] back-to-back pixels");
      clearStats();
      randomVec(); vecQ.push_back(tmpVec);
      randomVec(); vecQ.push_back(tmpVec);
      runUntilDrained(0, 60);
      chk("t2_no_bubble", maxRun, 16);
      chk("t2_sready_pulses", sreadyPulses, 2);
      chk("t2_tlast_count", tlastCount, 1);
      chk("t2_fd_count", fdCount, 1);

      $display("[TB] backpressure 1,0,0,1");
      clearStats();
      randomVec(); vecQ.push_back(tmpVec);
      for (int c = 0; c < 64; c++) tmpVec[c*8 +: 8] = 8'(c * 3 - 90);
      vecQ.push_back(tmpVec);
      runUntilDrained(1, 100);
      chk("t3_accepts", acceptCount, 16);

      $display("[TB] reset mid-stream");
      clearStats();
      randomVec(); vecQ.push_back(tmpVec);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      chk("t5_beats_before_reset", acceptCount, 3);
      doReset(1);

      $display("[TB] frame markers over 4 pixels");
      clearStats();
      for (int p = 0; p < 4; p++) begin
         randomVec();
         vecQ.push_back(tmpVec);
      end
      runUntilDrained(0, 80);
      chk("t4_tlast_count", tlastCount, 1);
      chk("t4_fd_count", fdCount, 1);
      chk("t4_tuser_count", tuserCount, 2);

      $display("[TB] padding with COUT=20, no ReLU");
      sel = 1'b1;
      doReset(1);
      clearStats();
      tmpVec = '0;
      for (int c = 0; c < 20; c++) tmpVec[c*8 +: 8] = 8'hFB;
      vecQ.push_back(tmpVec);
      runUntilDrained(0, 20);
      chk("t6_beats", tvalidCycles, 3);
      chk("t6_beat2", lastData, 64'h00000000FBFBFBFB);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/pw_out_serializer.md
Name: pw_out_serializer

Overview:
- Downstream stage of the 1x1 pointwise convolution engine.
- Takes one saturated COUT-channel int8 result vector per pixel and optionally applies ReLU.
- Serialises the vector into LANES-channel AXI-Stream beats for the writeback/DMA path.
- Tracks pixels per frame and drives first-beat and last-beat frame markers (tuser, tlast).

Parameters:
DATA_W, 8, bits per channel value (signed)
COUT, 64, channels per input vector
LANES, 8, channels per output beat
RELU_EN, 1, 1 = clamp negative values to 0 at capture; 0 = pass-through
PIX_PER_FRAME, 196, pixels per frame, used for tuser/tlast/frame_done

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input vector valid
s_ready  out  1  input vector accepted when s_valid && s_ready
s_vec  in  COUT*DATA_W  channel c is at bits [c*DATA_W +: DATA_W]
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  LANES*DATA_W  channels beat*LANES+l, lane l at [l*DATA_W +: DATA_W]
m_axis_tuser  out  1  first beat of first pixel of a frame
m_axis_tlast  out  1  last beat of last pixel of a frame
frame_done  out  1  one-cycle pulse after the frame's tlast beat is accepted

Behaviour:
- Derived constants: NUM_BEATS = ceil(COUT/LANES); beat_cnt width = clog2(NUM_BEATS), min 1; pix_cnt width = clog2(PIX_PER_FRAME), min 1.
- States: IDLE, STREAM.
- IDLE:
  - s_ready=1, m_axis_tvalid=0.
  - On s_valid: capture s_vec into buf (ReLU applied if RELU_EN), beat_cnt<=0, go to STREAM.
- STREAM:
  - m_axis_tvalid=1; tdata = buf slice for beat_cnt.
  - Lanes with channel index >= COUT drive 0 (padding on the final beat when COUT % LANES != 0).
- Beat accept (tvalid && tready):
  - If beat_cnt != NUM_BEATS-1: beat_cnt+1.
  - Else the pixel is done: pix_cnt+1, wrapping to 0 after PIX_PER_FRAME-1.
- s_ready in STREAM = (beat_cnt==NUM_BEATS-1) && m_axis_tready. This is combinational from tready, giving zero-bubble back-to-back pixels.
- Pixel done in the same cycle as s_valid: capture the new vector, beat_cnt<=0, stay in STREAM.
- Pixel done without s_valid: go to IDLE.
- tuser = STREAM && beat_cnt==0 && pix_cnt==0.
- tlast = STREAM && beat_cnt==NUM_BEATS-1 && pix_cnt==PIX_PER_FRAME-1.
- frame_done: registered; 1 on the cycle after the tlast beat is accepted, otherwise 0.
- AXI rules:
  - tdata, tuser, tlast are stable while tvalid && !tready.
  - tvalid never drops until the beat is accepted.
  - buf is never overwritten while a beat other than the final beat is pending.
- ReLU: value with sign bit set -> 0; otherwise unchanged. No other arithmetic.
- Latency:
  - Vector accepted at cycle t -> first beat valid at t+1.
  - Under constant tready, a pixel occupies exactly NUM_BEATS cycles.
- Reset (also mid-stream, even with a beat pending):
  - state=IDLE, beat_cnt=0, pix_cnt=0, buf=0, frame_done=0.
  - Outputs: tvalid=0, tuser=0, tlast=0, tdata=0, s_ready=1 on the first cycle after reset.
  - The partial pixel is discarded; the frame restarts at pixel 0.
- Backpressure on the final beat: s_ready stays 0 and the upstream must hold s_valid/s_vec.

Test Plan:
- Single pixel, defaults, RELU_EN=1, tready=1:
  - Stimulus: s_vec channel c = c-32 (c=0..63).
  - Beats 0..3 carry all zeros; beat 4 carries 0..7; beat 7 carries 24..31.
  - tuser=1 on beat 0 only; tvalid high for exactly 8 cycles, then returns to IDLE.
- Back-to-back pixels, s_valid held high:
  - 16 consecutive tvalid cycles, no bubble.
  - s_ready pulses only on beat 7 of each pixel.
- Backpressure, tready toggling 1,0,0,1 repeatedly:
  - tdata/tuser/tlast hold while stalled.
  - Sequence of 8 beats per pixel is identical to the stall-free run.
- Frame markers, PIX_PER_FRAME=3, 4 pixels:
  - tlast on beat 7 of pixel 2 only; frame_done pulses the next cycle.
  - Pixel 3 carries tuser=1.
- Padding, COUT=20, LANES=8, RELU_EN=0:
  - Stimulus: all channels = -5.
  - 3 beats; beat 2 has lanes 0..3 = 0xFB and lanes 4..7 = 0.
- Reset mid-stream, asserted during beat 3 with tready=0:
  - Next cycle: tvalid=0, s_ready=1.
  - The next accepted pixel starts at beat 0 with tuser=1.
